// File: rtl/rv32i_dbg_apb_ctrl_pkg.sv
// Shared types and register map for the debug APB run-control block.
package rv32i_dbg_apb_ctrl_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        STEP   = 2'd2
    } dbg_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_HALTREQ = 2'd1,
        CAUSE_BP      = 2'd2,
        CAUSE_STEP    = 2'd3
    } dbg_cause_e;

    // Word offsets (paddr[4:2])
    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_STATUS   = 3'd1;
    localparam logic [2:0] OFF_DPC      = 3'd2;
    localparam logic [2:0] OFF_BP0_ADDR = 3'd3;
    localparam logic [2:0] OFF_BP0_CTRL = 3'd4;
    localparam logic [2:0] OFF_BP1_ADDR = 3'd5;
    localparam logic [2:0] OFF_BP1_CTRL = 3'd6;
    localparam logic [2:0] OFF_HIT_CNT  = 3'd7;

endpackage

// File: rtl/rv32i_dbg_apb_ctrl_if.sv
// APB slave bus bundle for the debug register file.
interface rv32i_dbg_apb_ctrl_if
    import rv32i_dbg_apb_ctrl_pkg::*;
#(
    parameter int APB_AW = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [APB_AW-1:0] paddr;
    logic [XLEN-1:0]   pwdata;
    logic [XLEN-1:0]   prdata;
    logic              pready;
    logic              pslverr;

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );
endinterface

// File: rtl/rv32i_dbg_apb_ctrl.sv
// Debug APB register file and RUN/HALTED/STEP run-control FSM.
// Optional feature: define RV32I_DBG_HIT_CNT_EN to add the 16-bit breakpoint
// halt counter at offset 0x1C; without it 0x1C reads 0 and ignores writes.
//
//   state  | meaning
//   RUN    | CPU free-running, breakpoints armed (unless skip_bp)
//   HALTED | CPU stalled, DPC tracks the stalled PC
//   STEP   | CPU released for exactly one retired instruction
module rv32i_dbg_apb_ctrl
    import rv32i_dbg_apb_ctrl_pkg::*;
#(
    parameter int APB_AW     = 8,
    parameter int RESET_HALT = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    rv32i_dbg_apb_ctrl_if.slave apb,
    input  logic [XLEN-1:0]     pc,
    input  logic                instr_retired,
    input  logic                bp_hit,
    input  logic [1:0]          bp_index,
    output logic [XLEN-1:0]     bp0_addr,
    output logic [XLEN-1:0]     bp1_addr,
    output logic                bp0_en,
    output logic                bp1_en,
    output logic                cpu_stall,
    output logic                dbg_halted
);

    localparam dbg_state_e RST_STATE = (RESET_HALT != 0) ? HALTED : RUN;
    localparam dbg_cause_e RST_CAUSE = (RESET_HALT != 0) ? CAUSE_HALTREQ : CAUSE_NONE;

    dbg_state_e      state, state_nxt;
    dbg_cause_e      cause, cause_nxt;
    logic [1:0]      bp_idx, bp_idx_nxt;
    logic            skip_bp;
    logic [XLEN-1:0] dpc;
    logic [XLEN-1:0] hit_cnt_rd;

    logic       access, addr_ok, wr_en, ctrl_wr;
    logic       halt_req, resume_req, step_req, qualified_hit;
    logic [2:0] off;

    // Upper address bits and byte lane bits must be zero for a mapped access.
    assign access     = apb.psel & apb.penable;
    assign addr_ok    = (apb.paddr[APB_AW-1:5] == '0) && (apb.paddr[1:0] == 2'b00);
    assign off        = apb.paddr[4:2];
    assign wr_en      = access & apb.pwrite & addr_ok;
    assign ctrl_wr    = wr_en && (off == OFF_CTRL);
    assign halt_req   = ctrl_wr & apb.pwdata[0];
    assign resume_req = ctrl_wr & apb.pwdata[1];
    assign step_req   = ctrl_wr & apb.pwdata[2];

    assign qualified_hit = bp_hit & ~skip_bp;

    assign apb.pready  = 1'b1;
    assign apb.pslverr = access & ~addr_ok;

    // Stall is combinational so a breakpointed instruction never retires.
    assign cpu_stall  = (state == HALTED) | ((state == RUN) & qualified_hit);
    assign dbg_halted = (state == HALTED);

    // Next-state, halt cause and latched breakpoint index.
    always_comb begin
        state_nxt  = state;
        cause_nxt  = cause;
        bp_idx_nxt = bp_idx;
        unique case (state)
            RUN: begin
                if (qualified_hit) begin
                    state_nxt  = HALTED;
                    cause_nxt  = CAUSE_BP;
                    bp_idx_nxt = bp_index;
                end else if (halt_req) begin
                    state_nxt = HALTED;
                    cause_nxt = CAUSE_HALTREQ;
                end
            end
            HALTED: begin
                if (resume_req) begin
                    state_nxt = RUN;
                end else if (step_req) begin
                    state_nxt = STEP;
                end
            end
            STEP: begin
                if (instr_retired) begin
                    state_nxt = HALTED;
                    cause_nxt = CAUSE_STEP;
                end else if (halt_req) begin
                    state_nxt = HALTED;
                    cause_nxt = CAUSE_HALTREQ;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // FSM state register plus skip_bp, which lets the breakpointed
    // instruction execute once after leaving HALTED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RST_STATE;
            cause   <= RST_CAUSE;
            bp_idx  <= 2'b00;
            skip_bp <= 1'b0;
        end else begin
            state  <= state_nxt;
            cause  <= cause_nxt;
            bp_idx <= bp_idx_nxt;
            if ((state == HALTED) && (state_nxt != HALTED)) begin
                skip_bp <= 1'b1;
            end else if (instr_retired) begin
                skip_bp <= 1'b0;
            end
        end
    end

    // DPC follows pc on every cycle that ends in HALTED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dpc <= '0;
        end else if (state_nxt == HALTED) begin
            dpc <= pc;
        end
    end

    // Breakpoint configuration registers, writable in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp0_addr <= '0;
            bp1_addr <= '0;
            bp0_en   <= 1'b0;
            bp1_en   <= 1'b0;
        end else if (wr_en) begin
            if (off == OFF_BP0_ADDR) bp0_addr <= apb.pwdata;
            if (off == OFF_BP0_CTRL) bp0_en   <= apb.pwdata[0];
            if (off == OFF_BP1_ADDR) bp1_addr <= apb.pwdata;
            if (off == OFF_BP1_CTRL) bp1_en   <= apb.pwdata[0];
        end
    end

`ifdef RV32I_DBG_HIT_CNT_EN
    logic [15:0] hit_cnt;

    // Saturating count of breakpoint halts; a write wins over a same-cycle hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt <= '0;
        end else if (wr_en && (off == OFF_HIT_CNT)) begin
            hit_cnt <= '0;
        end else if ((state == RUN) && qualified_hit && (hit_cnt != 16'hFFFF)) begin
            hit_cnt <= hit_cnt + 16'd1;
        end
    end

    assign hit_cnt_rd = {{(XLEN-16){1'b0}}, hit_cnt};
`else
    assign hit_cnt_rd = '0;
`endif

    // Read mux: only drives data in a mapped access phase.
    always_comb begin
        apb.prdata = '0;
        if (access && addr_ok) begin
            unique case (off)
                OFF_STATUS:   apb.prdata = {{(XLEN-8){1'b0}}, bp_idx, cause, 2'b00,
                                            (state == STEP), (state == HALTED)};
                OFF_DPC:      apb.prdata = dpc;
                OFF_BP0_ADDR: apb.prdata = bp0_addr;
                OFF_BP0_CTRL: apb.prdata = {{(XLEN-1){1'b0}}, bp0_en};
                OFF_BP1_ADDR: apb.prdata = bp1_addr;
                OFF_BP1_CTRL: apb.prdata = {{(XLEN-1){1'b0}}, bp1_en};
                OFF_HIT_CNT:  apb.prdata = hit_cnt_rd;
                default:      apb.prdata = '0;
            endcase
        end
    end

endmodule
